branch_ctrl: RTL



---
 rtl/branch_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/branch_ctrl.sv
// Execute-stage branch resolution: condition decode, registered PC redirect, fixed-length wrong-path flush.
// Optional branch statistics counters are built when BRANCH_STATS_EN is defined.
module branch_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_is_branch,
  input  logic        i_is_jump,
  input  logic        i_is_jalr,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_target,
  output logic        o_br_un,
  input  logic        i_br_less,
  input  logic        i_br_equal,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_flush,
  output logic        o_illegal,
  output logic        o_misaligned,
  input  logic        i_stats_clr,
  output logic [31:0] o_br_total,
  output logic [31:0] o_br_taken
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        cond, f3_bad;
  logic        accept, illegal, taken, go, mis;
  logic [31:0] eff_tgt;

  // Unsigned compare for BLTU/BGEU only.
  assign o_br_un = i_funct3[2] & i_funct3[1];

  always_comb begin
    cond   = 1'b0;
    f3_bad = 1'b0;
    case (i_funct3)
      3'b000:         cond = i_br_equal;
      3'b001:         cond = ~i_br_equal;
      3'b100, 3'b110: cond = i_br_less;
      3'b101, 3'b111: cond = ~i_br_less;
      default:        f3_bad = 1'b1;
    endcase
  end

  assign accept  = i_valid & (state == IDLE);
  assign illegal = i_is_branch & (i_is_jump | f3_bad);
  assign taken   = ~illegal & (i_is_jump | (i_is_branch & cond));
  assign eff_tgt = {i_target[31:1], i_target[0] & ~(i_is_jump & i_is_jalr)};
  // A taken target with bit 1 set traps instead of redirecting.
  assign go      = accept & taken & ~eff_tgt[1];
  assign mis     = accept & taken &  eff_tgt[1];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (go) begin
          state_nx = FLUSH;
          cnt_nx   = 4'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (cnt == 4'd0) state_nx = IDLE;
        else             cnt_nx   = cnt - 4'd1;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      o_redirect    <= 1'b0;
      o_redirect_pc <= 32'd0;
      o_flush       <= 1'b0;
      o_illegal     <= 1'b0;
      o_misaligned  <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      o_redirect   <= go;
      o_flush      <= (state_nx == FLUSH);
      o_illegal    <= accept & illegal;
      o_misaligned <= mis;
      if (go) o_redirect_pc <= eff_tgt;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] total_q, taken_q;
  logic        inc_total, inc_taken;

  assign inc_total = accept & i_is_branch & ~illegal;
  assign inc_taken = inc_total & go;

  // Saturating counters; clear wins over increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      total_q <= 32'd0;
      taken_q <= 32'd0;
    end else if (i_stats_clr) begin
      total_q <= 32'd0;
      taken_q <= 32'd0;
    end else begin
      if (inc_total && (total_q != 32'hFFFF_FFFF)) total_q <= total_q + 32'd1;
      if (inc_taken && (taken_q != 32'hFFFF_FFFF)) taken_q <= taken_q + 32'd1;
    end
  end

  assign o_br_total = total_q;
  assign o_br_taken = taken_q;
`else
  logic stats_unused;
  assign stats_unused = i_stats_clr;
  assign o_br_total   = 32'd0;
  assign o_br_taken   = 32'd0;
`endif

endmodule
